// File: rtl/cpu_debug_ocimem_ctrl.sv
// Sysclk-side debug memory controller: JTAG debug commands and an Avalon-MM CPU
// slave share one 32-bit RAM, with debug strobes always winning arbitration.
module cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, DBG_RD, DBG_CAP, DBG_WR, CPU_RD} state_t;

  state_t           state;
  logic [31:0]      mem [DEPTH];
  logic [31:0]      rd_data;
  logic             strobe;
  logic             dbg_in_range;
  logic             cpu_in_range;
  logic             cpu_wr_grant;
  logic             cpu_rd_accept;
  logic [IDX_W-1:0] dbg_idx;
  logic [IDX_W-1:0] cpu_idx;

  assign strobe        = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign dbg_in_range  = {1'b0, MonAReg} < DEPTH_V;
  assign cpu_in_range  = {1'b0, cpu_address} < DEPTH_V;
  assign dbg_idx       = MonAReg[IDX_W-1:0];
  assign cpu_idx       = cpu_address[IDX_W-1:0];
  assign cpu_wr_grant  = (state == IDLE) & ~strobe & cpu_write;
  assign cpu_rd_accept = (state == IDLE) & ~strobe & ~cpu_write & cpu_read;
  // A read is granted in its second cycle, when the captured word is on cpu_readdata.
  assign cpu_waitrequest = (cpu_read | cpu_write) &
                           ~(cpu_wr_grant | ((state == CPU_RD) & cpu_read));

  // RAM port: contents are never reset, but reset suppresses any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_readdata <= '0;
    end else begin
      if (state == DBG_WR && dbg_in_range) begin
        mem[dbg_idx] <= MonDReg;
      end else if (cpu_wr_grant && cpu_in_range) begin
        for (int i = 0; i < 4; i++) begin
          if (cpu_byteenable[i]) mem[cpu_idx][8*i +: 8] <= cpu_writedata[8*i +: 8];
        end
      end
      if (state == DBG_RD && dbg_in_range) rd_data <= mem[dbg_idx];
      if (cpu_rd_accept) cpu_readdata <= cpu_in_range ? mem[cpu_idx] : 32'h0;
    end
  end

  // Debug command FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      MonDReg       <= '0;
      MonAReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      if (state != IDLE && strobe) monitor_error <= 1'b1;
      case (state)
        IDLE: begin
          if (take_action_ocimem_a) begin
            MonAReg <= jdo[16+ADDR_W:17];
            if (jdo[34]) monitor_error <= 1'b0;
            if (jdo[35]) begin
              monitor_ready <= 1'b0;
              state         <= DBG_RD;
            end
          end else if (take_action_ocimem_b) begin
            MonDReg       <= jdo[34:3];
            monitor_ready <= 1'b0;
            state         <= DBG_WR;
          end else if (take_no_action_ocimem_a) begin
            monitor_ready <= 1'b0;
            state         <= DBG_RD;
          end else if (cpu_rd_accept) begin
            state <= CPU_RD;
          end
        end
        DBG_RD: state <= DBG_CAP;
        DBG_CAP: begin
          // MonAReg is unchanged since DBG_RD, so the range test still applies.
          if (dbg_in_range) MonDReg <= rd_data;
          else              monitor_error <= 1'b1;
          MonAReg       <= MonAReg + ADDR_ONE;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
        DBG_WR: begin
          if (!dbg_in_range) monitor_error <= 1'b1;
          MonAReg       <= MonAReg + ADDR_ONE;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
        CPU_RD:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// Scoreboard bench: a word-array model predicts debug/CPU results, a monitor compares them.
module tb_cpu_debug_ocimem_ctrl;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_a, take_b, take_na;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read, cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic              monitor_ready, monitor_error;

  cpu_debug_ocimem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
    .take_no_action_ocimem_a(take_na),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .MonDReg(MonDReg), .MonAReg(MonAReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] dreg;
    logic [7:0]  areg;
    logic        err;
  } dbg_exp_t;

  dbg_exp_t    dbg_q[$];
  logic [31:0] cpu_q[$];

  // Reference model state
  logic [31:0] ref_mem [256];
  logic [31:0] m_dreg;
  int          m_aptr;
  logic        m_err;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic void push_dbg();
    dbg_exp_t e;
    e.dreg = m_dreg;
    e.areg = 8'(m_aptr);
    e.err  = m_err;
    dbg_q.push_back(e);
  endfunction

  function automatic void model_read(input bit dropped_cmd);
    if (m_aptr < DEPTH) m_dreg = ref_mem[m_aptr];
    else                m_err  = 1'b1;
    m_aptr = (m_aptr + 1) % 256;
    if (dropped_cmd) m_err = 1'b1;
    push_dbg();
  endfunction

  // Monitor: compares on every completed debug op and every granted CPU read.
  bit rdy_prev = 1'b1;
  initial begin
    dbg_exp_t e;
    logic [31:0] c;
    forever begin
      @(negedge clk);
      if (reset) begin
        rdy_prev = 1'b1;
      end else begin
        if (monitor_ready && !rdy_prev) begin
          if (dbg_q.size() == 0) begin
            chk("dbg_unexpected_done", 32'd1, 32'd0);
          end else begin
            e = dbg_q.pop_front();
            chk("dbg_MonDReg", MonDReg, e.dreg);
            chk("dbg_MonAReg", 32'(MonAReg), 32'(e.areg));
            chk("dbg_error", 32'(monitor_error), 32'(e.err));
          end
        end
        rdy_prev = monitor_ready;
        if (cpu_read && !cpu_waitrequest) begin
          if (cpu_q.size() == 0) begin
            chk("cpu_unexpected_read", 32'd1, 32'd0);
          end else begin
            c = cpu_q.pop_front();
            chk("cpu_readdata", cpu_readdata, c);
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (monitor_ready) return;
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic issue_a(input int addr, input bit clr, input bit rd);
    m_aptr = addr;
    if (clr) m_err = 1'b0;
    if (rd) model_read(1'b0);
    @(posedge clk); #1;
    jdo = '0; jdo[24:17] = 8'(addr); jdo[34] = clr; jdo[35] = rd; take_a = 1'b1;
    @(posedge clk); #1;
    take_a = 1'b0;
    if (rd) begin
      wait_ready("set_a_read");
    end else begin
      @(negedge clk);
      chk("set_a_MonAReg", 32'(MonAReg), 32'(m_aptr));
      chk("set_a_error", 32'(monitor_error), 32'(m_err));
      chk("set_a_ready", 32'(monitor_ready), 32'd1);
    end
  endtask

  task automatic issue_b(input logic [31:0] data);
    m_dreg = data;
    if (m_aptr < DEPTH) ref_mem[m_aptr] = data;
    else                m_err = 1'b1;
    m_aptr = (m_aptr + 1) % 256;
    push_dbg();
    @(posedge clk); #1;
    jdo = '0; jdo[34:3] = data; take_b = 1'b1;
    @(posedge clk); #1;
    take_b = 1'b0;
    wait_ready("write_b");
  endtask

  task automatic issue_na();
    model_read(1'b0);
    @(posedge clk); #1;
    take_na = 1'b1;
    @(posedge clk); #1;
    take_na = 1'b0;
    wait_ready("read_next");
  endtask

  task automatic cpu_wr(input int addr, input logic [31:0] data, input logic [3:0] be,
                        output int waits);
    bit done;
    if (addr < DEPTH) ref_mem[addr] = merge(ref_mem[addr], data, be);
    @(posedge clk); #1;
    cpu_address = 8'(addr); cpu_writedata = data; cpu_byteenable = be; cpu_write = 1'b1;
    waits = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) done = 1'b1;
      else waits++;
    end
    if (!done) chk("cpu_write_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cpu_write = 1'b0;
  endtask

  task automatic cpu_rd(input int addr, output int waits);
    bit done;
    cpu_q.push_back((addr < DEPTH) ? ref_mem[addr] : 32'h0);
    @(posedge clk); #1;
    cpu_address = 8'(addr); cpu_read = 1'b1;
    waits = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) done = 1'b1;
      else waits++;
    end
    if (!done) chk("cpu_read_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cpu_read = 1'b0;
  endtask

  initial begin
    int w, addr;
    logic [31:0] d;
    reset = 1'b1; jdo = '0; take_a = 0; take_b = 0; take_na = 0;
    cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0; cpu_byteenable = '0;
    m_dreg = '0; m_aptr = 0; m_err = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_MonDReg", MonDReg, 32'h0);
    chk("rst_MonAReg", 32'(MonAReg), 32'h0);
    chk("rst_ready", 32'(monitor_ready), 32'd1);
    chk("rst_error", 32'(monitor_error), 32'd0);
    chk("rst_cpu_readdata", cpu_readdata, 32'h0);
    chk("rst_waitrequest", 32'(cpu_waitrequest), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Give every implemented word a known value.
    for (int i = 0; i < DEPTH; i++) begin
      cpu_wr(i, $urandom, 4'hF, w);
      chk("fill_write_waits", 32'(w), 32'd0);
    end

    issue_a(16, 1'b0, 1'b0);
    issue_b(32'hDEADBEEF);
    cpu_rd(16, w);
    chk("cpu_read_waits", 32'(w), 32'd1);
    issue_a(16, 1'b0, 1'b1);
    issue_na();

    issue_a(199, 1'b0, 1'b1);
    issue_na();
    issue_a(5, 1'b0, 1'b0);
    issue_a(5, 1'b1, 1'b0);
    issue_a(255, 1'b0, 1'b1);
    issue_a(0, 1'b1, 1'b0);
    issue_a(250, 1'b0, 1'b0);
    issue_b(32'hCAFEF00D);
    issue_a(0, 1'b1, 1'b0);

    cpu_wr(5, 32'hFFFFFFFF, 4'hF, w);
    cpu_wr(5, 32'h12345678, 4'b0011, w);
    cpu_rd(5, w);
    chk("cpu_read5_waits", 32'(w), 32'd1);

    // CPU write and debug write in the same cycle, same word: CPU lands last.
    issue_a(40, 1'b0, 1'b0);
    ref_mem[40] = 32'h0BADF00D;
    m_dreg = 32'h0BADF00D; m_aptr = 41; push_dbg();
    ref_mem[40] = 32'h600DCAFE;
    @(posedge clk); #1;
    jdo = '0; jdo[34:3] = 32'h0BADF00D; take_b = 1'b1;
    cpu_address = 8'd40; cpu_writedata = 32'h600DCAFE; cpu_byteenable = 4'hF; cpu_write = 1'b1;
    w = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) break;
      w++;
      @(posedge clk); #1 take_b = 1'b0;
    end
    @(posedge clk); #1 cpu_write = 1'b0;
    chk("arb_cpu_waits", 32'(w), 32'd2);
    cpu_rd(40, w);

    // Read-next while a read is in flight is dropped and flagged.
    m_aptr = 60; model_read(1'b1);
    @(posedge clk); #1;
    jdo = '0; jdo[24:17] = 8'd60; jdo[35] = 1'b1; take_a = 1'b1;
    @(posedge clk); #1 take_a = 1'b0; take_na = 1'b1;
    @(posedge clk); #1 take_na = 1'b0;
    wait_ready("dropped_cmd");
    issue_a(0, 1'b1, 1'b0);

    // Reset during a debug read.
    @(posedge clk); #1;
    jdo = '0; jdo[24:17] = 8'd70; jdo[35] = 1'b1; take_a = 1'b1;
    @(posedge clk); #1 take_a = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_aptr = 0; m_dreg = '0; m_err = 1'b0;
    @(negedge clk);
    chk("rst_rd_ready", 32'(monitor_ready), 32'd1);
    chk("rst_rd_MonDReg", MonDReg, 32'h0);
    chk("rst_rd_MonAReg", 32'(MonAReg), 32'h0);
    cpu_rd(70, w);

    // Reset during a debug write must leave the RAM word untouched.
    issue_a(80, 1'b0, 1'b0);
    @(posedge clk); #1;
    jdo = '0; jdo[34:3] = 32'h55AA55AA; take_b = 1'b1;
    @(posedge clk); #1 take_b = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_aptr = 0; m_dreg = '0; m_err = 1'b0;
    @(negedge clk);
    chk("rst_wr_ready", 32'(monitor_ready), 32'd1);
    chk("rst_wr_MonAReg", 32'(MonAReg), 32'h0);
    cpu_rd(80, w);

    // CPU out-of-range: write ignored, read returns 0, no debug error.
    cpu_wr(210, 32'h11111111, 4'hF, w);
    cpu_rd(210, w);
    issue_a(3, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, DEPTH-1));
      d = $urandom;
      case ($urandom_range(0, 5))
        0: issue_a(addr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        1: issue_b(d);
        2: issue_na();
        3: cpu_wr(addr, d, 4'($urandom_range(0, 15)), w);
        default: cpu_rd(addr, w);
      endcase
    end

    repeat (5) @(negedge clk);
    chk("dbg_queue_drained", 32'(dbg_q.size()), 32'd0);
    chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
